// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_ctrl_pipe : per-lane decode of instruction IDs into control fields,
//                    held in a valid/ready register with delay-slot tracking.
// Revision 1.0
// ---------------------------------------------------------------------------
module decode_ctrl_pipe #(
  parameter int ID_W  = 8,
  parameter int LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W*LANES-1:0]   in_id,
  input  logic [LANES-1:0]        in_lane_v,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_v,
  output logic [LANES-1:0]        out_jump,
  output logic [3*LANES-1:0]      out_branch,
  output logic [2*LANES-1:0]      out_regdst,
  output logic [2*LANES-1:0]      out_exttype,
  output logic [LANES-1:0]        out_link,
  output logic [LANES-1:0]        out_illegal,
  output logic [LANES-1:0]        out_ds
);

  // Shared instruction-ID list; any value above ID_SYSCALL is illegal.
  localparam logic [ID_W-1:0] ID_NOP   = ID_W'(0),  ID_ADD   = ID_W'(1),  ID_ADDU  = ID_W'(2);
  localparam logic [ID_W-1:0] ID_SUB   = ID_W'(3),  ID_SUBU  = ID_W'(4),  ID_SLT   = ID_W'(5);
  localparam logic [ID_W-1:0] ID_SLTU  = ID_W'(6),  ID_AND   = ID_W'(7),  ID_NOR   = ID_W'(8);
  localparam logic [ID_W-1:0] ID_OR    = ID_W'(9),  ID_XOR   = ID_W'(10), ID_SLL   = ID_W'(11);
  localparam logic [ID_W-1:0] ID_SRL   = ID_W'(12), ID_SRA   = ID_W'(13), ID_SLLV  = ID_W'(14);
  localparam logic [ID_W-1:0] ID_SRLV  = ID_W'(15), ID_SRAV  = ID_W'(16), ID_MFHI  = ID_W'(17);
  localparam logic [ID_W-1:0] ID_MFLO  = ID_W'(18), ID_MTHI  = ID_W'(19), ID_MTLO  = ID_W'(20);
  localparam logic [ID_W-1:0] ID_MULT  = ID_W'(21), ID_MULTU = ID_W'(22), ID_DIV   = ID_W'(23);
  localparam logic [ID_W-1:0] ID_DIVU  = ID_W'(24), ID_ADDI  = ID_W'(25), ID_ADDIU = ID_W'(26);
  localparam logic [ID_W-1:0] ID_SLTI  = ID_W'(27), ID_SLTIU = ID_W'(28), ID_ANDI  = ID_W'(29);
  localparam logic [ID_W-1:0] ID_ORI   = ID_W'(30), ID_XORI  = ID_W'(31), ID_LUI   = ID_W'(32);
  localparam logic [ID_W-1:0] ID_LB    = ID_W'(33), ID_LBU   = ID_W'(34), ID_LH    = ID_W'(35);
  localparam logic [ID_W-1:0] ID_LHU   = ID_W'(36), ID_LW    = ID_W'(37), ID_SB    = ID_W'(38);
  localparam logic [ID_W-1:0] ID_SH    = ID_W'(39), ID_SW    = ID_W'(40), ID_BEQ   = ID_W'(41);
  localparam logic [ID_W-1:0] ID_BNE   = ID_W'(42), ID_BGEZ  = ID_W'(43), ID_BGTZ  = ID_W'(44);
  localparam logic [ID_W-1:0] ID_BLEZ  = ID_W'(45), ID_BLTZ  = ID_W'(46), ID_BGEZAL = ID_W'(47);
  localparam logic [ID_W-1:0] ID_BLTZAL = ID_W'(48), ID_J    = ID_W'(49), ID_JAL   = ID_W'(50);
  localparam logic [ID_W-1:0] ID_JR    = ID_W'(51), ID_JALR  = ID_W'(52), ID_MFC0  = ID_W'(53);
  localparam logic [ID_W-1:0] ID_MTC0  = ID_W'(54), ID_ERET  = ID_W'(55), ID_SYSCALL = ID_W'(56);

  typedef struct packed {
    logic       jump;
    logic [2:0] branch;
    logic [1:0] regdst;
    logic [1:0] exttype;
    logic       link;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [ID_W-1:0] id);
    ctrl_t c;
    c = '0;
    case (id)
      ID_ADD, ID_ADDU, ID_SUB, ID_SUBU, ID_SLT, ID_SLTU, ID_AND, ID_NOR, ID_OR,
      ID_XOR, ID_SLL, ID_SRL, ID_SRA, ID_SLLV, ID_SRLV, ID_SRAV, ID_MFHI,
      ID_MFLO:                                   c.regdst = 2'd1;
      ID_NOP, ID_MTHI, ID_MTLO, ID_MULT, ID_MULTU, ID_DIV, ID_DIVU, ID_ANDI,
      ID_ORI, ID_XORI, ID_MFC0, ID_MTC0, ID_ERET, ID_SYSCALL: c = '0;
      ID_ADDI, ID_ADDIU, ID_SLTI, ID_SLTIU, ID_LB, ID_LBU, ID_LH, ID_LHU, ID_LW,
      ID_SB, ID_SH, ID_SW:                       c.exttype = 2'd1;
      ID_LUI:                                    c.exttype = 2'd2;
      ID_BEQ:    begin c.branch = 3'd1; c.exttype = 2'd1; end
      ID_BNE:    begin c.branch = 3'd2; c.exttype = 2'd1; end
      ID_BGEZ:   begin c.branch = 3'd3; c.exttype = 2'd1; end
      ID_BGTZ:   begin c.branch = 3'd4; c.exttype = 2'd1; end
      ID_BLEZ:   begin c.branch = 3'd5; c.exttype = 2'd1; end
      ID_BLTZ:   begin c.branch = 3'd6; c.exttype = 2'd1; end
      ID_BGEZAL: begin c.branch = 3'd3; c.exttype = 2'd1; c.link = 1'b1; c.regdst = 2'd2; end
      ID_BLTZAL: begin c.branch = 3'd6; c.exttype = 2'd1; c.link = 1'b1; c.regdst = 2'd2; end
      ID_J, ID_JR: c.jump = 1'b1;
      ID_JAL:    begin c.jump = 1'b1; c.link = 1'b1; c.regdst = 2'd2; end
      ID_JALR:   begin c.jump = 1'b1; c.link = 1'b1; c.regdst = 2'd1; end
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  ctrl_t            dec [LANES];
  logic [LANES-1:0] cf;
  logic [LANES-1:0] ds_next;
  logic             ds_pend;
  logic             young_cf;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign dec[k] = in_lane_v[k] ? decode(in_id[k*ID_W +: ID_W]) : '0;
    assign cf[k]  = dec[k].jump || (dec[k].branch != 3'd0);
    if (k == 0) begin : g_first
      assign ds_next[k] = in_lane_v[k] && ds_pend;
    end else begin : g_rest
      assign ds_next[k] = in_lane_v[k] && cf[k-1];
    end
  end

  // The youngest valid lane decides whether the next bundle starts in a delay slot.
  always_comb begin
    young_cf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (in_lane_v[k]) young_cf = cf[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      ds_pend     <= 1'b0;
      out_lane_v  <= '0;
      out_jump    <= '0;
      out_branch  <= '0;
      out_regdst  <= '0;
      out_exttype <= '0;
      out_link    <= '0;
      out_illegal <= '0;
      out_ds      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ds_pend   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      ds_pend    <= young_cf;
      out_lane_v <= in_lane_v;
      out_ds     <= ds_next;
      for (int k = 0; k < LANES; k++) begin
        out_jump[k]          <= dec[k].jump;
        out_branch[3*k +: 3] <= dec[k].branch;
        out_regdst[2*k +: 2] <= dec[k].regdst;
        out_exttype[2*k +: 2] <= dec[k].exttype;
        out_link[k]          <= dec[k].link;
        out_illegal[k]       <= dec[k].illegal;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// Bench for decode_ctrl_pipe (LANES=2): directed scenarios, then random traffic
// against a transaction-level reference model.
module tb_decode_ctrl_pipe;
  localparam int ID_W  = 8;
  localparam int LANES = 2;

  localparam int ADD = 1, ADDU = 2, ADDI = 25, ORI = 30, LW = 37, SW = 40;
  localparam int BEQ = 41, BLTZAL = 48, J = 49, JAL = 50, BAD = 200;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [ID_W*LANES-1:0] in_id;
  logic [LANES-1:0]      in_lane_v;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_v, out_jump, out_link, out_illegal, out_ds;
  logic [3*LANES-1:0]    out_branch;
  logic [2*LANES-1:0]    out_regdst, out_exttype;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.ID_W(ID_W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_lane_v(in_lane_v), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_v(out_lane_v),
    .out_jump(out_jump), .out_branch(out_branch), .out_regdst(out_regdst),
    .out_exttype(out_exttype), .out_link(out_link), .out_illegal(out_illegal),
    .out_ds(out_ds)
  );

  typedef struct {
    bit jump;
    int branch;
    int regdst;
    int exttype;
    bit link;
    bit illegal;
  } ref_t;

  // Decode rules by instruction category (ID ranges of the shared list).
  function automatic ref_t ref_dec(int id);
    ref_t r;
    r = '{default: 0};
    if (id > 56) begin
      r.illegal = 1'b1;
      return r;
    end
    r.jump = (id >= 49 && id <= 52);
    r.link = (id == 47 || id == 48 || id == 50 || id == 52);
    if (id >= 41 && id <= 48) r.branch = (id == 47) ? 3 : (id == 48) ? 6 : id - 40;
    if ((id >= 1 && id <= 18) || id == 52) r.regdst = 1;
    else if (id == 47 || id == 48 || id == 50) r.regdst = 2;
    if ((id >= 25 && id <= 28) || (id >= 33 && id <= 48)) r.exttype = 1;
    else if (id == 32) r.exttype = 2;
    return r;
  endfunction

  function automatic bit is_cf(ref_t r);
    return r.jump || (r.branch != 0);
  endfunction

  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_valid, m_pend;
  ref_t m_c [LANES];
  bit   m_lv [LANES];
  bit   m_ds [LANES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (m_valid) begin
      for (int k = 0; k < LANES; k++) begin
        chk($sformatf("l%0d_lane_v", k), 32'(out_lane_v[k]), 32'(m_lv[k]));
        chk($sformatf("l%0d_jump", k), 32'(out_jump[k]), 32'(m_c[k].jump));
        chk($sformatf("l%0d_branch", k), 32'(out_branch[3*k +: 3]), m_c[k].branch);
        chk($sformatf("l%0d_regdst", k), 32'(out_regdst[2*k +: 2]), m_c[k].regdst);
        chk($sformatf("l%0d_exttype", k), 32'(out_exttype[2*k +: 2]), m_c[k].exttype);
        chk($sformatf("l%0d_link", k), 32'(out_link[k]), 32'(m_c[k].link));
        chk($sformatf("l%0d_illegal", k), 32'(out_illegal[k]), 32'(m_c[k].illegal));
        chk($sformatf("l%0d_ds", k), 32'(out_ds[k]), 32'(m_ds[k]));
      end
    end
  endtask

  task automatic model_step();
    ref_t r0, r1;
    bit   acc;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    r0  = ref_dec(int'(in_id[7:0]));
    r1  = ref_dec(int'(in_id[15:8]));
    if (flush) begin
      m_valid = 1'b0;
      m_pend  = 1'b0;
    end else if (acc) begin
      m_lv[0] = in_lane_v[0];
      m_lv[1] = in_lane_v[1];
      m_c[0]  = in_lane_v[0] ? r0 : '{default: 0};
      m_c[1]  = in_lane_v[1] ? r1 : '{default: 0};
      m_ds[0] = in_lane_v[0] && m_pend;
      m_ds[1] = in_lane_v[1] && in_lane_v[0] && is_cf(r0);
      m_pend  = in_lane_v[1] ? is_cf(r1) : is_cf(r0);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int id0, input int id1, input logic [1:0] lv);
    in_valid  = v;
    in_id     = {8'(id1), 8'(id0)};
    in_lane_v = lv;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_id = '0; in_lane_v = '0;
    flush = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_pend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_fields", {out_lane_v, out_jump, out_branch, out_regdst, out_exttype,
                       out_link, out_illegal, out_ds}, 0);
    rst_n = 1'b1;

    // ADDI, then idle
    drive(1, ADDI, 0, 2'b01); tick();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_regdst", 32'(out_regdst[1:0]), 0);
    chk("addi_ext", 32'(out_exttype[1:0]), 1);
    chk("addi_rest", {out_jump[0], out_branch[2:0], out_link[0], out_illegal[0], out_ds[0]}, 0);
    drive(0, 0, 0, 2'b00); tick();
    chk("idle_valid", 32'(out_valid), 0);

    // delay slot across bundles with idle gap
    drive(1, BEQ, 0, 2'b01); tick();
    chk("beq_branch", 32'(out_branch[2:0]), 1);
    chk("beq_ds", 32'(out_ds[0]), 0);
    drive(0, 0, 0, 2'b00); repeat (3) tick();
    drive(1, ADD, 0, 2'b01); tick();
    chk("add_regdst", 32'(out_regdst[1:0]), 1);
    chk("add_ds", 32'(out_ds[0]), 1);
    tick();
    chk("add2_ds", 32'(out_ds[0]), 0);

    // stall with JAL held
    drive(1, JAL, 0, 2'b01); tick();
    out_ready = 1'b0; drive(1, LW, 0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_jal", {out_jump[0], out_link[0], 2'(out_regdst[1:0])}, 32'b1110);
    end
    out_ready = 1'b1; tick();
    chk("lw_ext", 32'(out_exttype[1:0]), 1);
    chk("lw_ds", 32'(out_ds[0]), 1);

    // two-lane bundle
    drive(1, BLTZAL, SW, 2'b11); tick();
    chk("l0_branch", 32'(out_branch[2:0]), 6);
    chk("l0_link_rd", {out_link[0], 2'(out_regdst[1:0]), 2'(out_exttype[1:0])}, 32'b11001);
    chk("l1_ext", 32'(out_exttype[3:2]), 1);
    chk("l1_ds", 32'(out_ds[1]), 1);
    drive(1, ADD, 0, 2'b01); tick();
    chk("after_pair_ds", 32'(out_ds[0]), 0);

    // flush drops the presented bundle and clears pending delay slot
    drive(1, J, 0, 2'b01); tick();
    flush = 1'b1; drive(1, ORI, 0, 2'b01); tick();
    chk("flush_valid", 32'(out_valid), 0);
    flush = 1'b0; tick();
    chk("ori_valid", 32'(out_valid), 1);
    chk("ori_ext", 32'(out_exttype[1:0]), 0);
    chk("ori_ds", 32'(out_ds[0]), 0);

    // illegal ID
    drive(1, BAD, 0, 2'b01); tick();
    chk("bad_illegal", 32'(out_illegal[0]), 1);
    chk("bad_rest", {out_jump[0], out_branch[2:0], out_regdst[1:0], out_exttype[1:0], out_link[0]}, 0);
    drive(1, ADDU, 0, 2'b01); tick();
    chk("addu_ds", 32'(out_ds[0]), 0);
    chk("addu_regdst", 32'(out_regdst[1:0]), 1);

    // asynchronous reset in the middle of a stall
    drive(1, JAL, 0, 2'b01); tick();
    out_ready = 1'b0; tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_jump", 32'(out_jump[0]), 0);
    m_valid = 1'b0; m_pend = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1; drive(0, 0, 0, 2'b00);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 70), $urandom_range(0, 70),
            {1'($urandom_range(0, 1)), 1'b1});
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; drive(0, 0, 0, 2'b00);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, parametrised decode-stage control generator for the MIPS core. It sits between fetch/ID-lookup and execute. It maps up to LANES instruction IDs per cycle to jump/branch/regDst/extType controls, plus new link, illegal and delay-slot flags. It holds the result in a valid/ready pipeline register with flush support.

## Interface
- ID_W, 8: width of one instruction ID, drawn from the shared instruction-ID list.
- LANES, 1: instructions per bundle (1 or 2); lane 0 is the oldest.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: input bundle valid.
- in_ready, out, 1: stage can accept a bundle.
- in_id, in, ID_W*LANES: instruction IDs; lane k occupies bits [k*ID_W +: ID_W].
- in_lane_v, in, LANES: per-lane valid; lane 0 is always set when in_valid is high.
- flush, in, 1: exception/ERET squash.
- out_valid, out, 1: output bundle valid.
- out_ready, in, 1: execute accepts the bundle.
- out_lane_v, out, LANES: registered per-lane valid.
- out_jump, out, LANES: J, JAL, JR, JALR.
- out_branch, out, 3*LANES: 0 none, 1 BEQ, 2 BNE, 3 BGEZ/BGEZAL, 4 BGTZ, 5 BLEZ, 6 BLTZ/BLTZAL, 7 unused.
- out_regdst, out, 2*LANES: 0 rt, 1 rd, 2 $31.
- out_exttype, out, 2*LANES: 0 zero-extend, 1 sign-extend, 2 LUI upper.
- out_link, out, LANES: JAL, JALR, BGEZAL, BLTZAL.
- out_illegal, out, LANES: ID not in the instruction list.
- out_ds, out, LANES: lane is in a branch delay slot.

## Operation
- Per-lane combinational map (ID → fields). Every field not listed is 0.
  - regDst=1: ADD, ADDU, SUB, SUBU, SLT, SLTU, AND, NOR, OR, XOR, all shifts, MFHI, MFLO, JALR.
  - regDst=2: JAL, BGEZAL, BLTZAL.
  - regDst=0: all other IDs, including MFC0.
  - extType=1: ADDI, ADDIU, SLTI, SLTIU, loads, stores, all branches.
  - extType=2: LUI.
  - extType=0: ANDI, ORI, XORI.
- Illegal IDs:
  - out_illegal=1.
  - All other fields 0.
  - The lane does not create a delay slot.
- Acceptance: the bundle is accepted when in_valid && in_ready && !flush.
  - in_ready = !out_valid || out_ready.
- Delay slot within a bundle (LANES=2): out_ds[1] = lane0 valid && (jump[0] || branch[0]≠0).
- Delay slot across bundles: register ds_pend.
  - Set on acceptance when the youngest valid lane is a jump or branch.
  - Cleared on acceptance otherwise.
  - Lane 0 of the next accepted bundle gets out_ds[0]=ds_pend.
  - ds_pend holds across idle and stall cycles.
- Output register:
  - Loads all fields on acceptance.
  - Holds them unchanged while out_valid && !out_ready.
  - Invalid lanes output all-zero fields.
- Flush:
  - Next cycle: out_valid=0 and ds_pend=0.
  - An input presented in the flush cycle is dropped.
  - Flush wins over a simultaneous stall or acceptance.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 bundle per cycle when out_ready is held high.
- Reset values (rst_n low, asynchronous): out_valid=0, ds_pend=0, and all out_* fields 0.
  - in_ready therefore reads 1 after reset.
- Reset asserted mid-stall discards the held bundle immediately.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_id to outputs.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and outputs are stable cycle-to-cycle.
- out_valid && out_ready with a new acceptance in the same cycle: the register is replaced with no bubble.
- out_valid && out_ready with no acceptance: out_valid=0 next cycle.

## Test plan
- Reset/idle, LANES=1:
  - Stimulus: release rst_n, then present ADDI at cycle 1 with out_ready=1.
  - Required: cycle 2 shows out_valid=1, regdst=0, exttype=1, others 0; cycle 3 shows out_valid=0.
- Delay slot across bundles, LANES=1:
  - Stimulus: BEQ, then 3 idle cycles, then ADD.
  - Required: BEQ gives branch=1, ds=0; ADD gives regdst=1, ds=1; a following ADD gives ds=0.
- Stall, LANES=1:
  - Stimulus: JAL accepted, then out_ready=0 for 4 cycles while in_valid=1 with LW.
  - Required: JAL fields (jump=1, link=1, regdst=2) held and in_ready=0 for those 4 cycles; LW appears the cycle after out_ready rises, with ds=1.
- Two lanes, LANES=2:
  - Stimulus: bundle {lane0 BLTZAL, lane1 SW}.
  - Required: lane0 branch=6, link=1, regdst=2, exttype=1; lane1 exttype=1, ds=1; ds_pend=0 afterwards.
- Flush:
  - Stimulus: J accepted; next cycle flush=1 with ORI presented; then ORI re-presented.
  - Required: out_valid=0 after flush; ORI is dropped in the flush cycle; re-presented ORI gives exttype=0, ds=0.
- Illegal ID:
  - Stimulus: an ID outside the list, then ADDU.
  - Required: illegal=1 with all other fields 0; ADDU gives ds=0.
